// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch/decode shared widths and the queued instruction entry type
//   ADDR_W        pc / address width
//   INSTR_W       instruction word width
//   fetch_entry_t {instr, pc} as handed from fetch to decode
package fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-2 circular FIFO of fetched entries with synchronous flush
//   clk, rst      clock, synchronous active-high reset
//   push, din     write din (caller guarantees !full)
//   pop, dout     advance head (caller guarantees count != 0); dout is the head
//   flush         empty the FIFO at this edge, overriding push/pop
//   full, count   occupancy status
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_pkg::fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 din,
  output entry_t                 dout,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  entry_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  assign dout = mem_q[rd_q];
  assign full = cnt_q == (PW+1)'(DEPTH);
  assign count = cnt_q;
  always_comb begin
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: fetch stage between program_counter and decode with replay-on-full
//   pc / imem_addr           address issued this cycle, forwarded to instruction memory
//   imem_rdata               word for the previous cycle's address
//   ex_jump, ex_jump_addr    execute redirect (flushes the buffer)
//   pc_jump, pc_jump_addr    merged redirect back to program_counter
//   ins_valid/ready/data/pc  decode handshake on the FIFO head
module instr_fetch_buffer #(
  parameter int WIDTH = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   pc,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               ex_jump,
  input  logic [WIDTH-1:0]   ex_jump_addr,
  output logic               pc_jump,
  output logic [WIDTH-1:0]   pc_jump_addr,
  output logic               ins_valid,
  input  logic               ins_ready,
  output logic [INSTR_W-1:0] ins_data,
  output logic [WIDTH-1:0]   ins_pc
);
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [WIDTH-1:0]   pc;
  } entry_t;
  logic [WIDTH-1:0] s1_pc_q;
  logic s1_valid_q, accept, full, replay;
  logic [$clog2(DEPTH):0] count;
  entry_t head;
  // A word that finds the FIFO full is dropped and its pc re-requested, so order is kept
  assign accept = s1_valid_q && !ex_jump;
  assign replay = accept && full;
  assign imem_addr = pc;
  assign pc_jump = !rst && (ex_jump || replay);
  assign pc_jump_addr = ex_jump ? ex_jump_addr : s1_pc_q;
  assign ins_valid = count != '0;
  assign ins_data = head.instr;
  assign ins_pc = head.pc;
  // Requests issued in a redirecting cycle are wrong-path and never captured
  always_ff @(posedge clk) begin
    s1_pc_q <= pc;
    s1_valid_q <= rst ? 1'b0 : !pc_jump;
  end
  fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(accept && !full),
    .pop(ins_valid && ins_ready),
    .flush(ex_jump),
    .din('{instr: imem_rdata, pc: s1_pc_q}),
    .dout(head),
    .full(full),
    .count(count)
  );
endmodule
